// File: rtl/msrv32_wb_ctrl_if.sv
// Writeback control bundle: retiring instruction,
// data-memory return and register-file write drive.
interface msrv32_wb_ctrl_if;
  logic        wb_valid_in;
  logic        wb_rf_wr_en_in;
  logic [4:0]  wb_rd_addr_in;
  logic [1:0]  wb_sel_in;
  logic [31:0] alu_result_in;
  logic [31:0] pc_plus_4_in;
  logic [31:0] imm_in;
  logic [2:0]  load_funct3_in;
  logic [1:0]  load_addr_lsb_in;
  logic [31:0] dmem_rdata_in;
  logic        dmem_rvalid_in;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        wr_en_out;
  logic        stall_out;
  logic        misaligned_load_out;
  logic        bus_err_out;

  modport master (
    output wb_valid_in, wb_rf_wr_en_in,
    output wb_rd_addr_in, wb_sel_in,
    output alu_result_in, pc_plus_4_in,
    output imm_in, load_funct3_in,
    output load_addr_lsb_in,
    output dmem_rdata_in, dmem_rvalid_in,
    input  rd_addr_out, rd_out, wr_en_out,
    input  stall_out, misaligned_load_out,
    input  bus_err_out
  );

  modport slave (
    input  wb_valid_in, wb_rf_wr_en_in,
    input  wb_rd_addr_in, wb_sel_in,
    input  alu_result_in, pc_plus_4_in,
    input  imm_in, load_funct3_in,
    input  load_addr_lsb_in,
    input  dmem_rdata_in, dmem_rvalid_in,
    output rd_addr_out, rd_out, wr_en_out,
    output stall_out, misaligned_load_out,
    output bus_err_out
  );
endinterface

// File: rtl/msrv32_wb_ctrl.sv
// Writeback controller: selects rd data, waits on
// load returns with timeout, formats loaded data.
module msrv32_wb_ctrl #(
  parameter int TIMEOUT = 15
) (
  input logic msrv32_mp_clk_in,
  input logic msrv32_mp_rst_in,
  msrv32_wb_ctrl_if.slave bus
);

  localparam int CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_ld_rd;
  logic          r_ld_wr;
  logic [2:0]    r_ld_f3;
  logic [1:0]    r_ld_lsb;
  logic [4:0]    r_rd_addr;
  logic [31:0]   r_rd;
  logic          r_wr_en;
  logic          r_stall;
  logic          r_mis;
  logic          r_berr;

  logic [31:0]   w_sel_data;
  logic          w_mis;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld_data;

  // Non-load source mux
  always_comb begin
    w_sel_data = bus.alu_result_in;
    unique case (bus.wb_sel_in)
      2'b00: w_sel_data = bus.alu_result_in;
      2'b01: w_sel_data = bus.alu_result_in;
      2'b10: w_sel_data = bus.pc_plus_4_in;
      2'b11: w_sel_data = bus.imm_in;
    endcase
  end

  // Half needs even offset; word and wider need offset 0
  always_comb begin
    w_mis = 1'b0;
    if (bus.load_funct3_in[1])
      w_mis = (bus.load_addr_lsb_in != 2'b00);
    else if (bus.load_funct3_in[0])
      w_mis = bus.load_addr_lsb_in[0];
  end

  // Extract and extend the returned load data
  always_comb begin
    w_byte = bus.dmem_rdata_in[7:0];
    unique case (r_ld_lsb)
      2'b00: w_byte = bus.dmem_rdata_in[7:0];
      2'b01: w_byte = bus.dmem_rdata_in[15:8];
      2'b10: w_byte = bus.dmem_rdata_in[23:16];
      2'b11: w_byte = bus.dmem_rdata_in[31:24];
    endcase
    w_half = r_ld_lsb[1] ?
      bus.dmem_rdata_in[31:16] :
      bus.dmem_rdata_in[15:0];
    w_ld_data = bus.dmem_rdata_in;
    unique case (r_ld_f3)
      3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100: w_ld_data = {24'd0, w_byte};
      3'b001: w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101: w_ld_data = {16'd0, w_half};
      default: w_ld_data = bus.dmem_rdata_in;
    endcase
  end

  // Writeback FSM with registered outputs
  always_ff @(posedge msrv32_mp_clk_in or
              posedge msrv32_mp_rst_in) begin
    if (msrv32_mp_rst_in) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ld_rd   <= '0;
      r_ld_wr   <= 1'b0;
      r_ld_f3   <= '0;
      r_ld_lsb  <= '0;
      r_rd_addr <= '0;
      r_rd      <= '0;
      r_wr_en   <= 1'b0;
      r_stall   <= 1'b0;
      r_mis     <= 1'b0;
      r_berr    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.wb_valid_in) begin
            if (bus.wb_sel_in != 2'b01) begin
              r_wr_en   <= bus.wb_rf_wr_en_in &&
                           (bus.wb_rd_addr_in != 5'd0);
              r_rd_addr <= bus.wb_rd_addr_in;
              r_rd      <= w_sel_data;
            end else if (w_mis) begin
              r_mis <= 1'b1;
            end else begin
              r_ld_rd  <= bus.wb_rd_addr_in;
              r_ld_wr  <= bus.wb_rf_wr_en_in;
              r_ld_f3  <= bus.load_funct3_in;
              r_ld_lsb <= bus.load_addr_lsb_in;
              r_cnt    <= '0;
              r_stall  <= 1'b1;
              r_state  <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          if (bus.dmem_rvalid_in) begin
            r_wr_en   <= r_ld_wr && (r_ld_rd != 5'd0);
            r_rd_addr <= r_ld_rd;
            r_rd      <= w_ld_data;
            r_stall   <= 1'b0;
            r_state   <= IDLE;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_berr  <= 1'b1;
            r_stall <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.rd_addr_out         = r_rd_addr;
  assign bus.rd_out              = r_rd;
  assign bus.wr_en_out           = r_wr_en;
  assign bus.stall_out           = r_stall;
  assign bus.misaligned_load_out = r_mis;
  assign bus.bus_err_out         = r_berr;

endmodule
